bcd_to_bin: RTL and testbench
=============================

# bcd_to_bin

Sequential 3-digit BCD-to-binary converter for the oven controller. It turns a keypad/switch-entered temperature setpoint (hundreds, tens, ones) into a 10-bit binary value for the comparator and PID path. It is the inverse of the existing binary-to-BCD display conversion. It uses iterative reverse double-dabble, with a start/done handshake and one shift step per clock.

## Interface
- No parameters; digit count (3) and result width (10) are fixed.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: conversion request; sampled only in IDLE.
- `hund` in 4: hundreds BCD digit.
- `tens` in 4: tens BCD digit.
- `ones` in 4: ones BCD digit.
- `bin` out 10: converted value, registered, held between conversions.
- `busy` out 1: high from accept until done pulse, inclusive.
- `done` out 1: single-cycle completion pulse.
- `err` out 1: invalid digit flag for last conversion, held until next accept.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Edge with `start`=1 loads a 22-bit work register: {hund, tens, ones, 10'b0}.
  - Clears `err`, sets `busy`, clears a 4-bit step counter, and goes to SHIFT.
- SHIFT, once per cycle:
  - Logical right shift of the work register by 1.
  - Then, for each 4-bit BCD field, if the field is ≥8, subtract 3 (mod 16 per field).
  - Counter increments. After the 10th step, go to DONE.
- DONE, one cycle:
  - `bin` ← work[9:0], `done`=1, then IDLE with `busy`=0.
- Result is 100·hund + 10·tens + ones, range 0..999. This always fits in 10 bits, so no overflow path exists.
- `start` while not in IDLE is ignored: not queued, no effect on the current conversion.
- Inputs are sampled only at accept; changes during SHIFT are ignored.
- Reset values: `bin`=0, `busy`=0, `done`=0, `err`=0, state IDLE, counter 0.
- Reset asserted mid-conversion aborts immediately. No `done` pulse; `bin` returns to 0.

## Timing
- Accept edge E0 (IDLE, `start`=1). SHIFT steps occur on edges E1..E10.
- E10 registers DONE: `bin` valid and `done`=1 during the cycle after E10.
- Latency is 10 cycles from the accept edge to `done` visible.
- `busy`:
  - Rises after E0.
  - Falls after E11, the same edge that drops `done`.
- The next `start` can be accepted at E11 if high. Back-to-back throughput is 1 conversion per 11 cycles.
- `bin` changes only on the DONE-entry edge; it is stable at all other times.

## Configuration
- Macro: `BCD2BIN_DIGIT_CHECK_EN`.
- Defined:
  - At accept, any digit >9 sets `err`=1.
  - The SHIFT phase is skipped: DONE is entered at E1 and `done` pulses after E1.
  - `bin` keeps its previous value. `err` holds until the next accept.
- Undefined:
  - `err` is constant 0.
  - All inputs go through the full 10-step conversion. The result for invalid digits is deterministic but unspecified.

## Test plan
- Reset, then `start` with 9/8/7: `done` pulses 10 cycles after accept; `bin`=987 (0x3DB), `err`=0, `busy` high for 11 cycles.
- 0/0/0, then 4/5/0 back-to-back (`start` held high): `bin`=0, then `bin`=450; second accept lands on the edge that clears the first `done`.
- 3/5/0 accepted, then `start` pulsed at cycle 4 with 1/1/1: only one `done`; `bin`=350.
- 2/0/0 accepted, `rst_n` low at cycle 5: all outputs 0 immediately; no `done`; next 2/0/0 gives `bin`=200.
- With `BCD2BIN_DIGIT_CHECK_EN`, after `bin`=123, `start` with 1/A/3: `done` one cycle after accept, `err`=1, `bin` stays 123. A following 0/0/9 gives `err`=0, `bin`=9.
- Exhaustive sweep of 0..999: `bin` equals the decimal value every time and `err`=0.

Source files
------------

// File: rtl/bcd_to_bin.sv
// Sequential 3-digit BCD to 10-bit binary converter (reverse double-dabble, one step per clock).
// Optional macro BCD2BIN_DIGIT_CHECK_EN: flags digits >9 on err and skips the shift phase.
module bcd_to_bin (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] hund,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [9:0] bin,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int         WORK_W    = 22;
  localparam int         BIN_W     = 10;
  localparam logic [3:0] LAST_STEP = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          step;
  logic [WORK_W-1:0]   work;
  logic [WORK_W-1:0]   work_next;
  logic                accept;
  logic                skip_shift;

  // A BCD field that reads >=8 after the right shift held a 1 carried in from the
  // digit above (worth 5 here, but 8 in binary), so pull it back by 3.
  function automatic logic [3:0] fix_field(input logic [3:0] f);
    return (f >= 4'd8) ? (f - 4'd3) : f;
  endfunction

  function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
    logic [WORK_W-1:0] s;
    s        = w >> 1;
    s[21:18] = fix_field(s[21:18]);
    s[17:14] = fix_field(s[17:14]);
    s[13:10] = fix_field(s[13:10]);
    return s;
  endfunction

  // DONE also accepts, which lets a held start land on the edge that clears done.
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign work_next = dabble_step(work);

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic bad_digits;
  logic skip_reg;
  logic err_reg;

  assign bad_digits = (hund > 4'd9) || (tens > 4'd9) || (ones > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else if (accept) begin
      skip_reg <= bad_digits;
      err_reg  <= bad_digits;
    end
  end

  assign skip_shift = skip_reg;
  assign err        = err_reg;
`else
  assign skip_shift = 1'b0;
  assign err        = 1'b0;
`endif

  // Work register is pure data: loaded at accept, shifted while in SHIFT.
  always_ff @(posedge clk) begin
    if (accept) begin
      work <= {hund, tens, ones, {BIN_W{1'b0}}};
    end else if (state == SHIFT) begin
      work <= work_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= 4'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bin   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SHIFT;
            step  <= 4'd0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          step <= step + 4'd1;
          if (skip_shift) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (step == LAST_STEP) begin
            // Final shift and result capture share this edge.
            state <= DONE;
            done  <= 1'b1;
            bin   <= work_next[BIN_W-1:0];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  a_done_busy : assert property (@(posedge clk) disable iff (!rst_n) done |-> busy);
  a_step_range : assert property (@(posedge clk) disable iff (!rst_n)
                                   (state == SHIFT) |-> (step <= LAST_STEP));

endmodule

// File: tb/tb_bcd_to_bin.sv
// Randomized scoreboard bench for bcd_to_bin; expected values come from decimal arithmetic.
module tb_bcd_to_bin;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] hund;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [9:0] bin;
  logic       busy;
  logic       done;
  logic       err;

  bcd_to_bin dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .hund  (hund),
    .tens  (tens),
    .ones  (ones),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int done_cyc;
    int value;
    bit bad;
  } entry_t;

  entry_t sb[$];
  bit     busy_map[int];
  int     cyc = 0;
  int     free_edge = 0;
  int     cur_bin = 0;
  int     cur_err = 0;
  int     tests = 0;
  int     fails = 0;
  logic   exp_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every output against the model once per cycle, mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_bin", int'(bin), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
    end else begin
      exp_done = 1'b0;
      foreach (sb[i]) if (sb[i].acc == cyc) cur_err = sb[i].bad ? 1 : 0;
      if (sb.size() > 0 && sb[0].done_cyc == cyc) begin
        exp_done = 1'b1;
        if (!sb[0].bad) cur_bin = sb[0].value;
        void'(sb.pop_front());
      end
      check("done", int'(done), int'(exp_done));
      check("bin", int'(bin), cur_bin);
      check("err", int'(err), cur_err);
      check("busy", int'(busy), busy_map.exists(cyc) ? 1 : 0);
    end
  end

  // Drive one cycle of inputs; the model decides whether the next edge accepts.
  task automatic drive(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                       input logic st, output bit taken);
    entry_t e;
    bit     bad;
    int     span;
    @(posedge clk);
    #1;
    hund  = h;
    tens  = t;
    ones  = o;
    start = st;
    taken = 1'b0;
    if (st && rst_n && (cyc + 1 >= free_edge)) begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
      bad  = (h > 9) || (t > 9) || (o > 9);
      span = bad ? 1 : 10;
`else
      bad  = 1'b0;
      span = 10;
`endif
      e.acc      = cyc + 1;
      e.done_cyc = e.acc + span;
      e.value    = 100 * int'(h) + 10 * int'(t) + int'(o);
      e.bad      = bad;
      sb.push_back(e);
      for (int i = 0; i <= span; i++) busy_map[e.acc + i] = 1'b1;
      free_edge = e.acc + span + 1;
      taken = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    bit tk;
    for (int i = 0; i < n; i++) drive(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                      4'($urandom_range(0, 9)), 1'b0, tk);
  endtask

  task automatic convert(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    bit tk;
    int n;
    n = 0;
    do begin
      drive(h, t, o, 1'b1, tk);
      n++;
    end while (!tk && n < 20);
    if (!tk) check("accept_budget", 0, 1);
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    sb.delete();
    busy_map.delete();
    cur_bin   = 0;
    cur_err   = 0;
    free_edge = 0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit tk;
    rst_n = 1'b0;
    start = 1'b0;
    hund  = 4'd0;
    tens  = 4'd0;
    ones  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // 987, full latency and busy window
    convert(4'd9, 4'd8, 4'd7);
    idle(14);

    // back-to-back with start held high
    convert(4'd0, 4'd0, 4'd0);
    repeat (12) drive(4'd4, 4'd5, 4'd0, 1'b1, tk);
    drive(4'd4, 4'd5, 4'd0, 1'b0, tk);
    idle(12);

    // start during conversion is ignored
    convert(4'd3, 4'd5, 4'd0);
    idle(3);
    drive(4'd1, 4'd1, 4'd1, 1'b1, tk);
    if (tk) check("ignored_start_model", 1, 0);
    idle(12);

    // reset mid-conversion aborts
    convert(4'd2, 4'd0, 4'd0);
    idle(4);
    apply_reset(2);
    idle(1);
    convert(4'd2, 4'd0, 4'd0);
    idle(12);

`ifdef BCD2BIN_DIGIT_CHECK_EN
    convert(4'd1, 4'd2, 4'd3);
    idle(11);
    convert(4'd1, 4'hA, 4'd3);
    idle(3);
    convert(4'd0, 4'd0, 4'd9);
    idle(12);
`endif

    // exhaustive sweep, with random ignored starts and input churn while busy
    for (int v = 0; v < 1000; v++) begin
      convert(4'(v / 100), 4'((v / 10) % 10), 4'(v % 10));
      drive(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            1'($urandom_range(0, 1)), tk);
    end
    idle(12);

    // random conversions with random gaps
    for (int k = 0; k < 200; k++) begin
      logic [3:0] h, t, o;
      h = 4'($urandom_range(0, 9));
      t = 4'($urandom_range(0, 9));
      o = 4'($urandom_range(0, 9));
`ifdef BCD2BIN_DIGIT_CHECK_EN
      if ($urandom_range(0, 4) == 0) t = 4'($urandom_range(10, 15));
`endif
      convert(h, t, o);
      idle($urandom_range(0, 13));
    end

    idle(15);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
